// File: rtl/mips_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : mips_prog_loader
// Description : Byte-stream program writer for the MIPS32 unified memory.
//               Assembles big-endian words, writes them from address 0,
//               holds the core until the HLT word is stored, then pulses go.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_prog_loader #(
    parameter int         ADDR_W    = 10,
    parameter int         MAX_WORDS = 1024,
    parameter logic [5:0] HLT_OP    = 6'b111111
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_go,
    output logic [ADDR_W:0]   word_count,
    output logic              err_overflow
);

    localparam logic [1:0]      c_idle      = 2'd0;
    localparam logic [1:0]      c_load      = 2'd1;
    localparam logic [1:0]      c_fin       = 2'd2;
    localparam logic [1:0]      c_done      = 2'd3;
    localparam logic [ADDR_W:0] c_max_words = (ADDR_W + 1)'(MAX_WORDS);
    localparam logic [ADDR_W:0] c_one       = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [31:0]       r_word;
    logic [1:0]        r_bcnt;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_cpu_go;
    logic [ADDR_W:0]   r_word_count;
    logic              r_err;

    logic              w_in_ready;
    logic              w_accept;
    logic [31:0]       w_word_next;
    logic              w_last_byte;
    logic              w_is_hlt;
    logic              w_at_limit;
    logic              w_start_ok;

    assign w_in_ready  = (r_state == c_load);
    assign w_accept    = in_valid & w_in_ready;
    assign w_word_next = {r_word[23:0], in_data};
    assign w_last_byte = w_accept && (r_bcnt == 2'd3);
    assign w_is_hlt    = (w_word_next[31:26] == HLT_OP);
    assign w_at_limit  = ((r_word_count + c_one) == c_max_words);
    assign w_start_ok  = start && ((r_state == c_idle) || (r_state == c_done));

    // State register
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a session ends on HLT or on reaching the word limit
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (start) w_state_next = c_load;
            c_load:  if (w_last_byte && (w_is_hlt || w_at_limit)) w_state_next = c_fin;
            c_fin:   w_state_next = c_done;
            c_done:  if (start) w_state_next = c_load;
            default: w_state_next = c_idle;
        endcase
    end

    // Datapath: word assembly, write strobe, counters and core control
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_word       <= 32'd0;
            r_bcnt       <= 2'd0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
            r_cpu_hold   <= 1'b1;
            r_cpu_go     <= 1'b0;
            r_word_count <= '0;
            r_err        <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_cpu_go <= 1'b0;
            // A new session re-arms the hold and forgets the previous result
            if (w_start_ok) begin
                r_word_count <= '0;
                r_err        <= 1'b0;
                r_bcnt       <= 2'd0;
                r_cpu_hold   <= 1'b1;
            end
            if (w_accept) begin
                r_word <= w_word_next;
                r_bcnt <= r_bcnt + 2'd1;
                if (r_bcnt == 2'd3) begin
                    r_mem_we     <= 1'b1;
                    r_mem_addr   <= r_word_count[ADDR_W-1:0];
                    r_mem_wdata  <= w_word_next;
                    r_word_count <= r_word_count + c_one;
                    if (!w_is_hlt && w_at_limit) begin
                        r_err <= 1'b1;
                    end
                end
            end
            // Leaving FIN: release the core only for a clean load
            if (r_state == c_fin) begin
                r_cpu_go   <= ~r_err;
                r_cpu_hold <= r_err;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign cpu_hold     = r_cpu_hold;
    assign cpu_go       = r_cpu_go;
    assign word_count   = r_word_count;
    assign err_overflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mips_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_prog_loader
// Description : Directed self-checking bench for mips_prog_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_prog_loader;

    localparam int ADDR_W = 10;

    logic              clk1 = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              cpu_go;
    logic [ADDR_W:0]   word_count;
    logic              err_overflow;

    int total = 0;
    int fails = 0;
    bit gap   = 1'b0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int                go_cnt = 0;
    bit                prev_we = 1'b0;
    bit                b2b = 1'b0;
    logic [31:0]       expw[4];

    mips_prog_loader #(
        .ADDR_W   (ADDR_W),
        .MAX_WORDS(4),
        .HLT_OP   (6'b111111)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_hold    (cpu_hold),
        .cpu_go      (cpu_go),
        .word_count  (word_count),
        .err_overflow(err_overflow)
    );

    always #5 clk1 = ~clk1;

    // Write/go monitor sampled mid-cycle
    always @(negedge clk1) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (mem_we && prev_we) b2b <= 1'b1;
        prev_we <= mem_we;
        if (cpu_go) go_cnt <= go_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            @(posedge clk1); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk1);
        while (!in_ready && n < 20) begin
            @(negedge clk1);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk1); #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        go_cnt = 0;
    endtask

    task automatic check_writes(input int n, input string tag);
        check({tag, "_nwrites"}, 64'(wr_addr.size()), 64'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check({tag, "_addr"}, 64'(wr_addr[i]), 64'(i));
            check({tag, "_data"}, 64'(wr_data[i]), 64'(expw[i]));
        end
    endtask

    task automatic check_hlt_latency(input string tag, input logic [ADDR_W-1:0] a);
        @(negedge clk1);
        check({tag, "_we"},    64'(mem_we),    64'd1);
        check({tag, "_rdy"},   64'(in_ready),  64'd0);
        check({tag, "_go0"},   64'(cpu_go),    64'd0);
        check({tag, "_waddr"}, 64'(mem_addr),  64'(a));
        @(negedge clk1);
        check({tag, "_go1"},   64'(cpu_go),    64'd1);
        check({tag, "_hold"},  64'(cpu_hold),  64'd0);
        check({tag, "_we0"},   64'(mem_we),    64'd0);
        @(negedge clk1);
        check({tag, "_go2"},   64'(cpu_go),    64'd0);
        check({tag, "_hold2"}, 64'(cpu_hold),  64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h55;

        // Reset with in_valid high
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check("rst_ready", 64'(in_ready),     64'd0);
        check("rst_we",    64'(mem_we),       64'd0);
        check("rst_addr",  64'(mem_addr),     64'd0);
        check("rst_wdata", 64'(mem_wdata),    64'd0);
        check("rst_hold",  64'(cpu_hold),     64'd1);
        check("rst_go",    64'(cpu_go),       64'd0);
        check("rst_wc",    64'(word_count),   64'd0);
        check("rst_err",   64'(err_overflow), 64'd0);
        @(posedge clk1); #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk1); #1;
        check("idle_ready", 64'(in_ready), 64'd0);
        clear_log();

        // Continuous 3-word load; a start pulse mid-load must be ignored
        expw[0] = 32'h2801000A; expw[1] = 32'h28020014; expw[2] = 32'hFC000000;
        pulse_start();
        check("load_ready", 64'(in_ready), 64'd1);
        send_word(expw[0]);
        send_byte(8'h28);
        send_byte(8'h02);
        start = 1'b1;
        send_byte(8'h00);
        start = 1'b0;
        send_byte(8'h14);
        send_word(expw[2]);
        check_hlt_latency("cont", 10'd2);
        check("cont_wc", 64'(word_count), 64'd3);
        check("cont_err", 64'(err_overflow), 64'd0);
        check_writes(3, "cont");
        check("cont_gocnt", 64'(go_cnt), 64'd1);

        // Same stream with in_valid toggling every other cycle, from DONE
        clear_log();
        gap = 1'b1;
        pulse_start();
        check("tog_hold_load", 64'(cpu_hold), 64'd1);
        check("tog_wc_clr", 64'(word_count), 64'd0);
        send_word(expw[0]);
        send_word(expw[1]);
        send_word(expw[2]);
        check_hlt_latency("tog", 10'd2);
        check("tog_wc", 64'(word_count), 64'd3);
        check_writes(3, "tog");
        check("tog_gocnt", 64'(go_cnt), 64'd1);
        gap = 1'b0;

        // Overflow: 4 non-HLT words with MAX_WORDS=4
        clear_log();
        for (int i = 0; i < 4; i++) expw[i] = 32'(i + 1);
        pulse_start();
        for (int i = 0; i < 4; i++) send_word(expw[i]);
        @(negedge clk1);
        check("ovf_rdy",  64'(in_ready),     64'd0);
        check("ovf_we",   64'(mem_we),       64'd1);
        check("ovf_err",  64'(err_overflow), 64'd1);
        check("ovf_wc",   64'(word_count),   64'd4);
        @(negedge clk1);
        check("ovf_go",   64'(cpu_go),       64'd0);
        check("ovf_hold", 64'(cpu_hold),     64'd1);
        repeat (3) @(negedge clk1);
        check("ovf_hold2", 64'(cpu_hold),    64'd1);
        check("ovf_err2",  64'(err_overflow), 64'd1);
        check("ovf_rdy2",  64'(in_ready),    64'd0);
        check("ovf_gocnt", 64'(go_cnt),      64'd0);
        check_writes(4, "ovf");

        // Reset mid-word discards the partial bytes
        clear_log();
        pulse_start();
        check("pr_err_clr", 64'(err_overflow), 64'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk1); #1;
        rst_n    = 1'b1;
        @(negedge clk1);
        check("pr_nowrite", 64'(wr_addr.size()), 64'd0);
        check("pr_rdy",  64'(in_ready), 64'd0);
        check("pr_hold", 64'(cpu_hold), 64'd1);
        expw[0] = 32'h28030005; expw[1] = 32'hFC000000;
        @(posedge clk1); #1;
        pulse_start();
        send_word(expw[0]);
        send_word(expw[1]);
        check_hlt_latency("pr", 10'd1);
        check("pr_wc", 64'(word_count), 64'd2);
        check_writes(2, "pr");

        // Reload from DONE with a single HLT word
        clear_log();
        expw[0] = 32'hFC000000;
        pulse_start();
        check("rl_hold", 64'(cpu_hold), 64'd1);
        send_byte(8'hFC);
        send_byte(8'h00);
        send_byte(8'h00);
        check("rl_hold_mid", 64'(cpu_hold), 64'd1);
        send_byte(8'h00);
        in_valid = 1'b0;
        check_hlt_latency("rl", 10'd0);
        check("rl_wc", 64'(word_count), 64'd1);
        check_writes(1, "rl");
        repeat (2) @(negedge clk1);
        check("rl_gocnt", 64'(go_cnt), 64'd1);
        check("we_spacing", 64'(b2b), 64'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Hardware program writer for the pipelined MIPS32 core's unified MEMORY.
- Accepts a byte stream (valid/ready), assembles big-endian 32-bit words and writes them to consecutive word addresses from 0. Holds the core in reset-hold until the HLT word has been written, then releases it with a one-cycle start pulse.
- Replaces bench-side direct MEMORY preloading; sits between a host link (UART/JTAG byte FIFO) and the memory write port.

Parameters:
- ADDR_W, 10, word-address width of MEMORY (1024 words).
- MAX_WORDS, 1024, load limit; must satisfy MAX_WORDS <= 2**ADDR_W.
- HLT_OP, 6'b111111, opcode that terminates a load.

Ports:
- clk1  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a load session; sampled only in IDLE or DONE.
- in_valid  in  1  byte available.
- in_data  in  8  stream byte; first byte of a word = bits [31:24].
- in_ready  out  1  loader accepts byte; transfer when in_valid & in_ready.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_W  word address for mem_we.
- mem_wdata  out  32  word for mem_we.
- cpu_hold  out  1  high = core kept halted/PC frozen.
- cpu_go  out  1  one-cycle pulse: core may reset PC to 0 and run.
- word_count  out  ADDR_W+1  words written this session.
- err_overflow  out  1  MAX_WORDS reached without HLT; sticky until next start/reset.

Behaviour:
- Reset (rst_n=0 at a clk1 edge): state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, cpu_go=0, word_count=0, err_overflow=0, byte counter=0. Reset mid-load abandons the partial word; no write issued.
- States:
  - IDLE: in_ready=0. start -> LOAD; clear word_count, err_overflow, byte counter.
  - LOAD: in_ready=1. Each accepted byte shifts into a 32-bit assembly register (word = {word[23:0], in_data}). The byte counter wraps 3->0.
    - On the 4th byte: next cycle mem_we=1, mem_addr=word_count[ADDR_W-1:0], mem_wdata=assembled word; word_count increments in that same cycle.
    - If assembled[31:26]==HLT_OP -> FIN.
    - Else if word_count+1 == MAX_WORDS -> FIN with err_overflow set in the write cycle.
    - Else remain in LOAD.
  - FIN: in_ready=0; the final word's mem_we occurs in this cycle. Next -> DONE.
  - DONE: in_ready=0, mem_we=0.
    - On entry cycle: cpu_go=1 for exactly one cycle; cpu_hold=0 from entry onward, unless err_overflow=1, in which case cpu_hold stays 1 and cpu_go is suppressed.
    - start in DONE -> LOAD, cpu_hold=1 the same cycle the state changes.
- Bytes are never dropped while in_ready=1. in_valid with in_ready=0 is ignored and does not count.
- start during LOAD or FIN is ignored.
- mem_we is never asserted for more than one consecutive cycle per word. Minimum spacing between writes is 4 cycles.
- Latency: HLT 4th-byte acceptance -> mem_we at +1 cycle -> cpu_go at +2 cycles.
- A partial word (1-3 bytes) left when reset asserts is discarded.

Test Plan:
- Reset with in_valid=1 -> all outputs at reset values, cpu_hold=1, no mem_we.
- start, then stream 28 01 00 0A, 28 02 00 14, FC 00 00 00 continuously ->
  - mem_we at addr 0 = 0x2801000A, addr 1 = 0x28020014, addr 2 = 0xFC000000;
  - word_count=3; cpu_go single pulse 2 cycles after the last byte; cpu_hold=0 afterwards.
- Same stream with in_valid toggled every other cycle -> identical writes and addresses; no extra or missing bytes.
- MAX_WORDS=4, stream 4 non-HLT words ->
  - 4 writes, addr 0-3; err_overflow=1;
  - cpu_hold stays 1; no cpu_go; in_ready=0 after the 16th byte.
- rst_n low after 2 bytes of word 1, then start and a full 2-word load ending in HLT -> first write at addr 0 contains only the new bytes.
- After DONE, start and load a single HLT word -> write 0xFC000000 at addr 0; word_count=1; cpu_hold 1 during load; cpu_go pulses once.
